// File: rtl/pool_game_pkg.sv
// Shared types and helpers for the pool game controller.
package pool_game_pkg;

  typedef enum logic [1:0] {
    S_AIM,
    S_ROLL,
    S_SETTLE,
    S_DONE
  } gameState_t;

  // Hole number 0 means any hole is accepted.
  localparam int HOLE_ANY = 0;

  // Adds a signed delta and clamps the result into [0, maxValue].
  function automatic int satAddSub(input int value, input int delta, input int maxValue);
    int sum;
    int result;
    sum = value + delta;
    if (sum < 0)
      result = 0;
    else if (sum > maxValue)
      result = maxValue;
    else
      result = sum;
    return result;
  endfunction

endpackage

// File: rtl/pool_game_controller_if.sv
// Game-controller bus: collision/HUD side is master, controller is slave.
interface pool_game_controller_if #(
  parameter int NUM_BALLS = 4,
  parameter int HOLE_W    = 3,
  parameter int SCORE_W   = 8,
  parameter int ATT_W     = 8
);
  logic                        startOfFrame;
  logic                        shotFire;
  logic [NUM_BALLS-1:0]        ballStopped;
  logic [NUM_BALLS-1:0]        ballHoleHit;
  logic [NUM_BALLS*HOLE_W-1:0] ballHoleNum;

  logic [NUM_BALLS-1:0]        ballShow;
  logic                        drawLine;
  logic [HOLE_W-1:0]           holeNumToHit;
  logic [SCORE_W-1:0]          score;
  logic [ATT_W-1:0]            attempts;
  logic                        resetGameN;
  logic                        gameFinished;
  logic                        gameWon;

  modport master (
    output startOfFrame, shotFire, ballStopped, ballHoleHit, ballHoleNum,
    input  ballShow, drawLine, holeNumToHit, score, attempts,
           resetGameN, gameFinished, gameWon
  );

  modport slave (
    input  startOfFrame, shotFire, ballStopped, ballHoleHit, ballHoleNum,
    output ballShow, drawLine, holeNumToHit, score, attempts,
           resetGameN, gameFinished, gameWon
  );
endinterface

// File: rtl/pocket_arbiter.sv
// Pending-pocket bookkeeping: one bit and one latched hole number per ball,
// granting the lowest pending index; the grant is cleared when consumed.
module pocket_arbiter #(
  parameter int NUM_BALLS = 4,
  parameter int HOLE_W    = 3
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic [NUM_BALLS-1:0]          capture,
  input  logic [NUM_BALLS*HOLE_W-1:0]   holeNumIn,
  input  logic                          consume,
  output logic                          grantValid,
  output logic [$clog2(NUM_BALLS)-1:0]  grantIdx,
  output logic [HOLE_W-1:0]             grantHole
);
  localparam int IDX_W = $clog2(NUM_BALLS);

  logic [NUM_BALLS-1:0]             pending;
  logic [NUM_BALLS-1:0]             grantOneHot;
  logic [NUM_BALLS-1:0][HOLE_W-1:0] holeLatch;

  assign grantValid  = |pending;
  assign grantOneHot = pending & (~pending + NUM_BALLS'(1));
  assign grantHole   = holeLatch[grantIdx];

  // Lowest set pending bit wins (descending scan, last hit sticks).
  always_comb begin
    grantIdx = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--)
      if (pending[i]) grantIdx = IDX_W'(i);
  end

  // Pending set on capture, cleared on consumed grant; hole latched with capture.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      pending   <= '0;
      holeLatch <= '0;
    end else begin
      pending <= (pending & ~(consume ? grantOneHot : '0)) | capture;
      for (int i = 0; i < NUM_BALLS; i++)
        if (capture[i]) holeLatch[i] <= holeNumIn[i*HOLE_W +: HOLE_W];
    end
  end
endmodule

// File: rtl/pool_game_controller.sv
// Pool game rules: shot sequencing, pocket scoring with combo streaks,
// ordered target holes, respawn and end-of-game detection.
module pool_game_controller
  import pool_game_pkg::*;
#(
  parameter int NUM_BALLS       = 4,
  parameter int NUM_HOLES       = 6,
  parameter int HOLE_W          = 3,
  parameter int SCORE_W         = 8,
  parameter int ATT_W           = 8,
  parameter int ATTEMPTS_INIT   = 5,
  parameter int HIT_SCORE       = 5,
  parameter int COMBO_BONUS     = 2,
  parameter int COMBO_MAX       = 3,
  parameter int FOUL_PENALTY    = 1,
  parameter int RESPAWN_OBJECTS = 0,
  parameter int SETTLE_FRAMES   = 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  pool_game_controller_if.slave  gameIf
);
  localparam int IDX_W     = $clog2(NUM_BALLS);
  localparam int STREAK_W  = $clog2(NUM_BALLS) + 1;
  localparam int FRAME_W   = $clog2(SETTLE_FRAMES + 2);
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  gameState_t state, stateNext;

  logic [NUM_BALLS-1:0] ballShowQ, ballShowD;
  logic [SCORE_W-1:0]   scoreQ, scoreD;
  logic [ATT_W-1:0]     attQ, attD;
  logic [HOLE_W-1:0]    targetQ, targetD;
  logic [STREAK_W-1:0]  streakQ, streakD;
  logic [FRAME_W-1:0]   frameQ, frameD;
  logic                 rgnQ, rgnD;
  logic                 wonQ, wonD;
  logic                 drawLineQ, finishedQ;

  logic [NUM_BALLS-1:0] captureMask;
  logic                 consume, grantValid;
  logic [IDX_W-1:0]     grantIdx;
  logic [HOLE_W-1:0]    grantHole;
  logic                 allStopped, objDown, allObjDown, settleDone;
  int                   comboLevel;

  // Pockets only count while rolling and only for balls still on the table.
  assign captureMask = (state == S_ROLL) ? (gameIf.ballHoleHit & ballShowQ) : '0;
  assign allStopped  = &(gameIf.ballStopped | ~ballShowQ);
  assign objDown     = ~&ballShowQ[NUM_BALLS-1:1];
  assign allObjDown  = ~|ballShowQ[NUM_BALLS-1:1];
  assign settleDone  = (int'(frameQ) + int'(gameIf.startOfFrame)) >= SETTLE_FRAMES;
  assign comboLevel  = (int'(streakQ) > COMBO_MAX) ? COMBO_MAX : int'(streakQ);

  pocket_arbiter #(
    .NUM_BALLS (NUM_BALLS),
    .HOLE_W    (HOLE_W)
  ) uArb (
    .clk        (clk),
    .resetN     (resetN),
    .capture    (captureMask),
    .holeNumIn  (gameIf.ballHoleNum),
    .consume    (consume),
    .grantValid (grantValid),
    .grantIdx   (grantIdx),
    .grantHole  (grantHole)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!resetN) state <= S_AIM;
    else         state <= stateNext;
  end

  // Next-state and datapath update; S_DONE holds everything.
  always_comb begin
    stateNext = state;
    ballShowD = ballShowQ & ~captureMask;
    scoreD    = scoreQ;
    attD      = attQ;
    targetD   = targetQ;
    streakD   = streakQ;
    frameD    = frameQ;
    rgnD      = 1'b1;
    wonD      = wonQ;
    consume   = 1'b0;
    unique case (state)
      S_AIM: begin
        if (gameIf.shotFire && attQ != '0) begin
          attD      = attQ - ATT_W'(1);
          streakD   = '0;
          stateNext = S_ROLL;
        end
      end
      S_ROLL: begin
        if (grantValid) begin
          consume = 1'b1;
          if (grantIdx == '0) begin
            scoreD  = SCORE_W'(satAddSub(int'(scoreQ), -FOUL_PENALTY, SCORE_MAX));
            streakD = '0;
          end else if (grantHole == targetQ || targetQ == HOLE_W'(HOLE_ANY)) begin
            scoreD  = SCORE_W'(satAddSub(int'(scoreQ),
                                         HIT_SCORE + COMBO_BONUS * comboLevel, SCORE_MAX));
            streakD = streakQ + STREAK_W'(1);
            if (targetQ == HOLE_W'(NUM_HOLES))
              targetD = HOLE_W'(HOLE_ANY);
            else if (targetQ != HOLE_W'(HOLE_ANY))
              targetD = targetQ + HOLE_W'(1);
          end else begin
            streakD = '0;
          end
        end else if (captureMask == '0 && allStopped) begin
          // Settling starts only once every pocket has been scored.
          stateNext = S_SETTLE;
          frameD    = '0;
        end
      end
      S_SETTLE: begin
        if (settleDone) begin
          if (!ballShowQ[0] || (RESPAWN_OBJECTS != 0 && objDown)) begin
            rgnD      = 1'b0;
            ballShowD = (RESPAWN_OBJECTS != 0) ? '1 : (ballShowQ | NUM_BALLS'(1));
          end
          if (RESPAWN_OBJECTS == 0 && allObjDown) begin
            wonD      = 1'b1;
            stateNext = S_DONE;
          end else if (attQ == '0) begin
            stateNext = S_DONE;
          end else begin
            stateNext = S_AIM;
          end
        end else if (gameIf.startOfFrame) begin
          frameD = frameQ + FRAME_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered game state and outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      ballShowQ <= '1;
      scoreQ    <= '0;
      attQ      <= ATT_W'(ATTEMPTS_INIT);
      targetQ   <= HOLE_W'(1);
      streakQ   <= '0;
      frameQ    <= '0;
      rgnQ      <= 1'b0;
      wonQ      <= 1'b0;
      drawLineQ <= 1'b1;
      finishedQ <= 1'b0;
    end else begin
      ballShowQ <= ballShowD;
      scoreQ    <= scoreD;
      attQ      <= attD;
      targetQ   <= targetD;
      streakQ   <= streakD;
      frameQ    <= frameD;
      rgnQ      <= rgnD;
      wonQ      <= wonD;
      drawLineQ <= (stateNext == S_AIM);
      finishedQ <= (stateNext == S_DONE);
    end
  end

  assign gameIf.ballShow     = ballShowQ;
  assign gameIf.drawLine     = drawLineQ;
  assign gameIf.holeNumToHit = targetQ;
  assign gameIf.score        = scoreQ;
  assign gameIf.attempts     = attQ;
  assign gameIf.resetGameN   = rgnQ;
  assign gameIf.gameFinished = finishedQ;
  assign gameIf.gameWon      = wonQ;
endmodule

// File: tb/tb_pool_game_controller.sv
// Bench for pool_game_controller: two instances (stay-down objects with 8-bit
// score, and respawning objects with 5-bit score) share one stimulus stream,
// each tracked by a shot-level rules model.
module tb_pool_game_controller;
  localparam int NB = 4;
  localparam int NH = 6;
  localparam int HW = 3;

  localparam int P_RESP [2] = '{0, 1};
  localparam int P_SMAX [2] = '{255, 31};
  localparam int P_ATT  [2] = '{5, 12};

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic             startOfFrame = 1'b0;
  logic             shotFire = 1'b0;
  logic [NB-1:0]    ballStopped = '1;
  logic [NB-1:0]    ballHoleHit = '0;
  logic [NB*HW-1:0] ballHoleNum = '0;

  pool_game_controller_if #(.NUM_BALLS(NB), .HOLE_W(HW), .SCORE_W(8), .ATT_W(8)) ifA ();
  pool_game_controller_if #(.NUM_BALLS(NB), .HOLE_W(HW), .SCORE_W(5), .ATT_W(8)) ifB ();

  assign ifA.startOfFrame = startOfFrame;
  assign ifA.shotFire     = shotFire;
  assign ifA.ballStopped  = ballStopped;
  assign ifA.ballHoleHit  = ballHoleHit;
  assign ifA.ballHoleNum  = ballHoleNum;
  assign ifB.startOfFrame = startOfFrame;
  assign ifB.shotFire     = shotFire;
  assign ifB.ballStopped  = ballStopped;
  assign ifB.ballHoleHit  = ballHoleHit;
  assign ifB.ballHoleNum  = ballHoleNum;

  pool_game_controller #(
    .NUM_BALLS(NB), .NUM_HOLES(NH), .HOLE_W(HW), .SCORE_W(8), .ATT_W(8),
    .ATTEMPTS_INIT(5), .RESPAWN_OBJECTS(0), .SETTLE_FRAMES(2)
  ) dutA (.clk(clk), .resetN(resetN), .gameIf(ifA));

  pool_game_controller #(
    .NUM_BALLS(NB), .NUM_HOLES(NH), .HOLE_W(HW), .SCORE_W(5), .ATT_W(8),
    .ATTEMPTS_INIT(12), .RESPAWN_OBJECTS(1), .SETTLE_FRAMES(2)
  ) dutB (.clk(clk), .resetN(resetN), .gameIf(ifB));

  logic [7:0]    oScore  [2];
  logic [7:0]    oAtt    [2];
  logic [NB-1:0] oShow   [2];
  logic [HW-1:0] oTarget [2];
  logic          oWon [2], oFin [2], oDraw [2], oRgn [2];

  assign oScore[0] = ifA.score;          assign oScore[1] = 8'(ifB.score);
  assign oAtt[0]   = ifA.attempts;       assign oAtt[1]   = ifB.attempts;
  assign oShow[0]  = ifA.ballShow;       assign oShow[1]  = ifB.ballShow;
  assign oTarget[0] = ifA.holeNumToHit;  assign oTarget[1] = ifB.holeNumToHit;
  assign oWon[0]   = ifA.gameWon;        assign oWon[1]   = ifB.gameWon;
  assign oFin[0]   = ifA.gameFinished;   assign oFin[1]   = ifB.gameFinished;
  assign oDraw[0]  = ifA.drawLine;       assign oDraw[1]  = ifB.drawLine;
  assign oRgn[0]   = ifA.resetGameN;     assign oRgn[1]   = ifB.resetGameN;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- rules model (one per instance) ----------------
  int mShow [2][NB];
  int mScore [2], mAtt [2], mTarget [2], mStreak [2];
  bit mWon [2], mFin [2], mActive [2], mRespawn [2];

  function automatic void mReset();
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < NB; b++) mShow[d][b] = 1;
      mScore[d] = 0; mAtt[d] = P_ATT[d]; mTarget[d] = 1; mStreak[d] = 0;
      mWon[d] = 0; mFin[d] = 0; mActive[d] = 0; mRespawn[d] = 0;
    end
  endfunction

  function automatic void mShotStart();
    for (int d = 0; d < 2; d++) begin
      mActive[d] = !mFin[d] && mAtt[d] > 0;
      if (mActive[d]) begin
        mAtt[d]--;
        mStreak[d] = 0;
      end
    end
  endfunction

  function automatic void mPocket(input int d, input int b, input int h);
    int s;
    if (!mActive[d] || mShow[d][b] == 0) return;
    mShow[d][b] = 0;
    if (b == 0) begin
      mScore[d] = (mScore[d] > 0) ? mScore[d] - 1 : 0;
      mStreak[d] = 0;
    end else if (h == mTarget[d] || mTarget[d] == 0) begin
      s = mScore[d] + 5 + 2 * ((mStreak[d] > 3) ? 3 : mStreak[d]);
      mScore[d] = (s > P_SMAX[d]) ? P_SMAX[d] : s;
      mStreak[d]++;
      if (mTarget[d] == NH) mTarget[d] = 0;
      else if (mTarget[d] != 0) mTarget[d]++;
    end else begin
      mStreak[d] = 0;
    end
  endfunction

  function automatic void mSettle(input int d);
    bit anyDown, allDown;
    anyDown = 0; allDown = 1;
    mRespawn[d] = 0;
    if (!mActive[d]) return;
    for (int b = 1; b < NB; b++)
      if (mShow[d][b] == 0) anyDown = 1; else allDown = 0;
    if (mShow[d][0] == 0 || (P_RESP[d] != 0 && anyDown)) begin
      mRespawn[d] = 1;
      mShow[d][0] = 1;
      if (P_RESP[d] != 0) for (int b = 1; b < NB; b++) mShow[d][b] = 1;
    end
    if (P_RESP[d] == 0 && allDown) begin
      mWon[d] = 1; mFin[d] = 1;
    end else if (mAtt[d] == 0) begin
      mFin[d] = 1;
    end
    mActive[d] = 0;
  endfunction

  function automatic int packShow(input int d);
    int r;
    r = 0;
    for (int b = 0; b < NB; b++) if (mShow[d][b] != 0) r |= (1 << b);
    return r;
  endfunction

  function automatic logic [NB*HW-1:0] holes4(input int h0, input int h1, input int h2, input int h3);
    return {HW'(h3), HW'(h2), HW'(h1), HW'(h0)};
  endfunction

  function automatic int pickHole();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6 && mTarget[0] != 0) return mTarget[0];
    if (r < 8 && mTarget[1] != 0) return mTarget[1];
    return $urandom_range(1, NH);
  endfunction

  // ---------------- stimulus / checking tasks ----------------
  task automatic checkAll(input string ph, input int expRgn);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_score%0d", ph, d),  int'(oScore[d]),  mScore[d]);
      chk($sformatf("%s_att%0d", ph, d),    int'(oAtt[d]),    mAtt[d]);
      chk($sformatf("%s_target%0d", ph, d), int'(oTarget[d]), mTarget[d]);
      chk($sformatf("%s_show%0d", ph, d),   int'(oShow[d]),   packShow(d));
      chk($sformatf("%s_won%0d", ph, d),    int'(oWon[d]),    int'(mWon[d]));
      chk($sformatf("%s_fin%0d", ph, d),    int'(oFin[d]),    int'(mFin[d]));
      chk($sformatf("%s_draw%0d", ph, d),   int'(oDraw[d]),   mFin[d] ? 0 : 1);
      chk($sformatf("%s_rgn%0d", ph, d),    int'(oRgn[d]),    expRgn);
    end
  endtask

  task automatic doReset(input string ph);
    resetN = 1'b0; shotFire = 1'b0; startOfFrame = 1'b0;
    ballHoleHit = '0; ballStopped = '1;
    @(negedge clk);
    mReset();
    checkAll({ph, "_inrst"}, 0);
    resetN = 1'b1;
    @(negedge clk);
    checkAll({ph, "_rst"}, 1);
  endtask

  task automatic fireShot(input string ph);
    shotFire = 1'b1; ballStopped = '0;
    @(negedge clk);
    shotFire = 1'b0;
    mShotStart();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_shotatt%0d", ph, d), int'(oAtt[d]), mAtt[d]);
      chk($sformatf("%s_shotdraw%0d", ph, d), int'(oDraw[d]), 0);
    end
  endtask

  task automatic pulseGroup(input logic [NB-1:0] mask, input logic [NB*HW-1:0] hv, input int waitN);
    ballHoleHit = mask; ballHoleNum = hv;
    for (int d = 0; d < 2; d++)
      for (int b = 0; b < NB; b++)
        if (mask[b]) mPocket(d, b, int'(hv[b*HW +: HW]));
    @(negedge clk);
    ballHoleHit = '0;
    repeat (waitN) @(negedge clk);
  endtask

  task automatic settleShot(input string ph);
    int low [2];
    bit done;
    low[0] = 0; low[1] = 0; done = 0;
    ballStopped = '1;
    for (int c = 0; c < 200 && !done; c++) begin
      startOfFrame = (c % 4 == 3);
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (!oRgn[d]) low[d]++;
      done = (oDraw[0] || oFin[0]) && (oDraw[1] || oFin[1]);
    end
    startOfFrame = 1'b0;
    if (!done) chk({ph, "_settle_timeout"}, 0, 1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) if (!oRgn[d]) low[d]++;
    for (int d = 0; d < 2; d++) begin
      mSettle(d);
      chk($sformatf("%s_rgnpulses%0d", ph, d), low[d], int'(mRespawn[d]));
    end
    checkAll(ph, 1);
  endtask

  initial begin
    int nG;
    logic [NB-1:0] m;
    logic [NB*HW-1:0] hv;

    // Single correct pocket.
    doReset("r0");
    fireShot("t1");
    pulseGroup(4'b0010, holes4(0, 1, 0, 0), NB + 1);
    settleShot("t1");

    // Three simultaneous pockets, serviced one per cycle; then a win.
    doReset("r1");
    fireShot("t2");
    pulseGroup(4'b1110, holes4(0, 1, 2, 3), 0);
    chk("t2_show_k", int'(oShow[0]), 1);
    chk("t2_score_k", int'(oScore[0]), 0);
    @(negedge clk);
    chk("t2_score_k1", int'(oScore[0]), 5);
    chk("t2_tgt_k1", int'(oTarget[0]), 2);
    chk("t2_scoreB_k1", int'(oScore[1]), 5);
    @(negedge clk);
    chk("t2_score_k2", int'(oScore[0]), 12);
    chk("t2_tgt_k2", int'(oTarget[0]), 3);
    @(negedge clk);
    chk("t2_score_k3", int'(oScore[0]), 21);
    chk("t2_tgt_k3", int'(oTarget[0]), 4);
    chk("t2_scoreB_k3", int'(oScore[1]), 21);
    settleShot("t2");
    fireShot("t2b");
    settleShot("t2b");

    // Cue ball foul at score 0.
    doReset("r2");
    fireShot("t3");
    pulseGroup(4'b0001, holes4(2, 0, 0, 0), NB + 1);
    settleShot("t3");

    // Run attempts out, then one more shot on a finished game.
    doReset("r3");
    for (int s = 0; s < 6; s++) begin
      fireShot($sformatf("t4s%0d", s));
      settleShot($sformatf("t4s%0d", s));
    end

    // Reset mid-shot with pockets pending.
    doReset("r4");
    fireShot("t5");
    pulseGroup(4'b0110, holes4(0, 1, 2, 0), 0);
    doReset("t5mid");
    fireShot("t5b");
    pulseGroup(4'b0010, holes4(0, 1, 0, 0), NB + 1);
    settleShot("t5b");

    // Random games.
    for (int g = 0; g < 6; g++) begin
      doReset($sformatf("g%0d", g));
      for (int s = 0; s < 14 && !(mFin[0] && mFin[1]); s++) begin
        nG = $urandom_range(0, 2);
        fireShot($sformatf("g%0ds%0d", g, s));
        for (int k = 0; k < nG; k++) begin
          m = NB'($urandom) & ~NB'(1);
          if ($urandom_range(0, 7) == 0) m[0] = 1'b1;
          for (int b = 0; b < NB; b++) hv[b*HW +: HW] = HW'(pickHole());
          pulseGroup(m, hv, NB + 1);
        end
        settleShot($sformatf("g%0ds%0d", g, s));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/pool_game_controller.md
# pool_game_controller

Parametrised successor to the two-ball game controller. It owns the game rules for a table with one cue ball and NUM_BALLS-1 object balls: shot sequencing, per-ball visibility and respawn, pocket arbitration, the ordered target-hole progression, combo scoring and end-of-game detection. It sits between the ball/hole collision logic and the score/HUD drawers and drives the game-wide `resetGameN`.

## Interface
Parameters
- NUM_BALLS, 4: total balls; index 0 is the cue ball (≥2)
- NUM_HOLES, 6: holes numbered 1..NUM_HOLES; hole number 0 means "any hole"
- HOLE_W, 3: hole-number width; 2^HOLE_W > NUM_HOLES
- SCORE_W, 8; ATT_W, 8: score and attempts widths
- ATTEMPTS_INIT, 5: shots per game
- HIT_SCORE, 5; COMBO_BONUS, 2; COMBO_MAX, 3; FOUL_PENALTY, 1
- RESPAWN_OBJECTS, 0: 1 = respawn pocketed object balls after every shot; 0 = they stay down
- SETTLE_FRAMES, 2: startOfFrame pulses to wait before respawn/decision

Ports
- clk  in  1  system clock
- resetN  in  1  synchronous, active-low reset
- startOfFrame  in  1  one-cycle frame strobe
- shotFire  in  1  one-cycle pulse when the player releases a shot
- ballStopped  in  NUM_BALLS  per-ball stopped flag
- ballHoleHit  in  NUM_BALLS  per-ball one-cycle pocket pulse
- ballHoleNum  in  NUM_BALLS*HOLE_W  packed hole number per ball, valid with its pulse
- ballShow  out  NUM_BALLS  ball visible
- drawLine  out  1  aiming line enabled
- holeNumToHit  out  HOLE_W  current target hole (0 = any)
- score  out  SCORE_W; attempts  out  ATT_W
- resetGameN  out  1  active-low game reset to ball-physics blocks
- gameFinished  out  1; gameWon  out  1

## Operation
- States: S_AIM, S_ROLL, S_SETTLE, S_DONE.
- S_AIM: drawLine=1. shotFire with attempts>0 → attempts−1, streak←0, → S_ROLL. shotFire is ignored in every other state.
- S_ROLL: pocket pulses are captured (see below). When no pending bits remain and every visible ball is stopped → S_SETTLE, frame counter←0.
- S_SETTLE: counts startOfFrame pulses. At SETTLE_FRAMES:
  - cue pocketed, or RESPAWN_OBJECTS=1 with any object pocketed → resetGameN=0 for exactly one cycle, and the affected balls' ballShow←1.
  - All objects pocketed (RESPAWN_OBJECTS=0) → gameWon←1, → S_DONE.
  - Else attempts==0 → S_DONE.
  - Else → S_AIM.
- S_DONE: gameFinished=1. All outputs are frozen. Only resetN exits this state.
- Pocket capture: a pulse on ball i while ballShow[i]=1 clears ballShow[i], sets pending[i] and latches its hole number. A pulse while ballShow[i]=0 is ignored.
- Service: one pending ball per cycle, lowest index first.
  - Cue: score −FOUL_PENALTY (floor 0), streak←0.
  - Object, hole==holeNumToHit or target==0: score + HIT_SCORE + COMBO_BONUS·min(streak,COMBO_MAX), saturating at 2^SCORE_W−1. Then streak+1, target advances 1→2→…→NUM_HOLES→0. The target stays 0 once reached.
  - Object, wrong hole: no score change, streak←0.
- Reset values: ballShow all 1, score 0, attempts ATTEMPTS_INIT, holeNumToHit 1, state S_AIM, pending 0, resetGameN 0, gameFinished 0, gameWon 0.

## Timing
- All outputs are registered; reset is applied on the clk edge while resetN=0.
- resetGameN is 0 during reset and rises on the first edge with resetN=1.
- Pulse sampled at edge k → ballShow low after edge k. If that ball is lowest pending, score and target update after edge k+1. Each further simultaneous pocket adds one cycle.
- shotFire at edge k → attempts decremented and drawLine low after edge k.
- S_ROLL→S_SETTLE cannot occur on the same edge as a capture.
- A startOfFrame coinciding with entry to S_SETTLE is not counted.
- Respawn pulse: resetGameN low for exactly one cycle, on the same edge that leaves S_SETTLE.
- resetN asserted mid-shot or mid-settle discards all pending and streak state.

## Structure
- Package `pool_game_pkg`: state enum, the hole-number "any" constant 0, and a saturating add/sub function.
- Sub-module `pocket_arbiter`: pending bitmask plus per-ball hole latches, lowest-index grant and clear. The controller consumes one grant per cycle.

## Test plan
- Single shot, ball 1 pocketed into hole 1 → score 5, holeNumToHit 2, attempts 4. With RESPAWN_OBJECTS=0, ballShow[1] stays 0 in S_AIM.
- Balls 1, 2 and 3 pulse on the same cycle into holes 1, 2, 3 → serviced in three consecutive cycles. Score 5 → 12 → 21; target ends at 4.
- Cue ball pocketed with score 0 → score stays 0, one-cycle resetGameN low after SETTLE_FRAMES, ballShow[0]=1.
- Score 254, SCORE_W=8, correct pocket → score 255 (saturated).
- Fire ATTEMPTS_INIT shots with no pockets → gameFinished=1 after the last settle. A further shotFire leaves attempts 0 and all outputs unchanged.
- Pocket every object ball in order → gameWon=1 and gameFinished=1. Then assert resetN for one cycle → all reset values restored.
